dac_source_scheduler: RTL and testbench

- Chooses which of NUM_SRC candidate 18-bit signed sample streams drives the 14-bit DAC channel.
- Candidate streams are the mapper and upsampler outputs of the various transmit paths.
- Source changes happen only on an LFSR frame boundary, followed by a midscale mute window, so the scope never shows a torn frame.
- Supports host-requested selection (switches/keys) and an auto-scan mode that rotates through sources every SCAN_FRAMES LFSR periods.

---
 rtl/dac_source_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dac_source_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_source_scheduler.sv
// Picks one of NUM_SRC signed sample streams for the DAC and switches only on frame
// boundaries, with a midscale mute window in between. dac_out is one clk behind sam_clk_ena.
module dac_source_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int SEL_W        = 2,
  parameter int DATA_W       = 18,
  parameter int DAC_W        = 14,
  parameter int MUTE_SAMPLES = 8,
  parameter int SCAN_FRAMES  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sam_clk_ena,
  input  logic                      sym_clk_ena,
  input  logic                      frame_mark,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel_req,
  input  logic                      sel_req_valid,
  input  logic                      auto_scan,
  output logic [DAC_W-1:0]          dac_out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      busy,
  output logic                      req_err,
  output logic [7:0]                switch_count
);

  localparam int MUTE_W = $clog2(MUTE_SAMPLES + 1);
  localparam int SCAN_W = $clog2(SCAN_FRAMES + 1);

  localparam logic [DAC_W-1:0]  MIDSCALE  = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [SEL_W:0]    NUM_SRC_X = (SEL_W+1)'(NUM_SRC);
  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_SRC - 1);
  localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_SAMPLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_FRAMES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    MUTE    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   pend_sel;
  logic               pend_valid;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [MUTE_W-1:0]  mute_cnt;

  logic               fe;
  logic               req_bad;
  logic               req_same;
  logic               req_acc;
  logic [SEL_W-1:0]   next_sel;
  logic [DAC_W-1:0]   src_top;
  logic [DAC_W-1:0]   conv_word;

  logic               scan_inc;
  logic               scan_fire;
  logic               mute_load;
  logic               mute_dec;
  logic               mute_exit;

  assign fe       = sym_clk_ena & frame_mark;
  assign req_bad  = sel_req_valid & ({1'b0, sel_req} >= NUM_SRC_X);
  assign req_same = (state == RUN) & ~pend_valid & (sel_req == cur_sel);
  assign req_acc  = sel_req_valid & ~req_bad & ~req_same;
  assign next_sel = (cur_sel == LAST_SEL) ? '0 : cur_sel + 1'b1;
  assign busy     = (state != RUN);

  // Only the top DAC_W bits of each sample are ever used (plain truncation).
  always_comb begin
    src_top = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        src_top = src_data[i*DATA_W + DATA_W - DAC_W +: DAC_W];
      end
    end
  end

  assign conv_word = {~src_top[DAC_W-1], src_top[DAC_W-2:0]};

  always_comb begin
    state_nxt = state;
    scan_inc  = 1'b0;
    scan_fire = 1'b0;
    mute_load = 1'b0;
    mute_dec  = 1'b0;
    mute_exit = 1'b0;
    case (state)
      RUN: begin
        if (pend_valid) begin
          state_nxt = PENDING;
        end else if (auto_scan && fe && !req_acc) begin
          // A scan trigger already sits on a frame boundary, so skip PENDING.
          if (scan_cnt == SCAN_LAST) begin
            scan_fire = 1'b1;
            mute_load = 1'b1;
            state_nxt = MUTE;
          end else begin
            scan_inc = 1'b1;
          end
        end
      end
      PENDING: begin
        if (fe) begin
          mute_load = 1'b1;
          state_nxt = MUTE;
        end
      end
      MUTE: begin
        if (sam_clk_ena) begin
          if (mute_cnt <= MUTE_W'(1)) begin
            mute_exit = 1'b1;
            state_nxt = RUN;
          end else begin
            mute_dec = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      dac_out      <= MIDSCALE;
      cur_sel      <= '0;
      pend_sel     <= '0;
      pend_valid   <= 1'b0;
      scan_cnt     <= '0;
      mute_cnt     <= '0;
      req_err      <= 1'b0;
      switch_count <= '0;
    end else begin
      state <= state_nxt;

      if (req_bad) begin
        req_err <= 1'b1;
      end

      if (scan_inc) begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (scan_fire) begin
        scan_cnt   <= '0;
        pend_sel   <= next_sel;
        pend_valid <= 1'b1;
      end

      if (mute_load) begin
        mute_cnt <= MUTE_LOAD;
      end else if (mute_dec) begin
        mute_cnt <= mute_cnt - 1'b1;
      end

      if (mute_exit) begin
        mute_cnt     <= '0;
        cur_sel      <= pend_sel;
        pend_valid   <= 1'b0;
        scan_cnt     <= '0;
        switch_count <= switch_count + 8'd1;
      end

      // Placed after the exit branch so a request in the final mute cycle stays pending.
      if (req_acc) begin
        pend_sel   <= sel_req;
        pend_valid <= 1'b1;
      end

      if (sam_clk_ena) begin
        dac_out <= (state == MUTE) ? MIDSCALE : conv_word;
      end
    end
  end

endmodule

// File: tb/tb_dac_source_scheduler.sv
// Directed stimulus for dac_source_scheduler; every DAC word is scored by a monitor
// against a queue filled by the driver, while control outputs are checked inline.
module tb_dac_source_scheduler;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 18;
  localparam int DAC_W   = 14;

  localparam logic [DATA_W-1:0] SRC0 = 18'h10000;
  localparam logic [DATA_W-1:0] SRC1 = 18'h1FFFF;
  localparam logic [DATA_W-1:0] SRC2 = 18'h38000;  // -18'sh08000
  localparam logic [DATA_W-1:0] SRC3 = 18'h20000;

  localparam logic [DAC_W-1:0] MID = 14'h2000;
  localparam logic [DAC_W-1:0] E_TAB [4] = '{14'h3000, 14'h3FFF, 14'h1800, 14'h0000};

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      sam_clk_ena = 1'b0;
  logic                      sym_clk_ena = 1'b0;
  logic                      frame_mark = 1'b0;
  logic [NUM_SRC*DATA_W-1:0] src_data = {SRC3, SRC2, SRC1, SRC0};
  logic [SEL_W-1:0]          sel_req = '0;
  logic                      sel_req_valid = 1'b0;
  logic                      auto_scan = 1'b0;
  logic [DAC_W-1:0]          dac_out;
  logic [SEL_W-1:0]          cur_sel;
  logic                      busy;
  logic                      req_err;
  logic [7:0]                switch_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DAC_W-1:0] exp_q [$];

  dac_source_scheduler #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DATA_W(DATA_W), .DAC_W(DAC_W),
    .MUTE_SAMPLES(8), .SCAN_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena),
    .frame_mark(frame_mark), .src_data(src_data), .sel_req(sel_req),
    .sel_req_valid(sel_req_valid), .auto_scan(auto_scan), .dac_out(dac_out),
    .cur_sel(cur_sel), .busy(busy), .req_err(req_err), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each registered sample strobe produces one DAC word to score.
  initial begin
    logic [DAC_W-1:0] e;
    forever begin
      @(posedge clk);
      if (sam_clk_ena && !reset) begin
        #1;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL dac_unexpected: got %0h, expected no word at %0t", dac_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("dac_out", int'(dac_out), int'(e));
        end
      end
    end
  end

  task automatic cyc(input logic sam, input logic sym, input logic fm, input logic rv,
                     input logic [SEL_W-1:0] rs, input logic [DAC_W-1:0] exp);
    @(negedge clk);
    sam_clk_ena   = sam;
    sym_clk_ena   = sym;
    frame_mark    = fm;
    sel_req_valid = rv;
    sel_req       = rs;
    if (sam && !reset) exp_q.push_back(exp);
    @(posedge clk);
    #2;
    sam_clk_ena   = 1'b0;
    sym_clk_ena   = 1'b0;
    frame_mark    = 1'b0;
    sel_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic fe_cyc();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic req(input logic [SEL_W-1:0] rs);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, rs, '0);
  endtask

  // n sample periods of 4 clk, strobe on the first clk of each
  task automatic per(input int n, input logic [DAC_W-1:0] exp);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, exp);
      idle(3);
    end
  endtask

  initial begin
    // Reset, including a strobe while held in reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(2);
    chk("rst_dac", int'(dac_out), int'(MID));
    chk("rst_cur_sel", int'(cur_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_err", int'(req_err), 0);
    chk("rst_switch_count", int'(switch_count), 0);
    reset = 1'b0;
    idle(1);
    chk("post_rst_dac_hold", int'(dac_out), int'(MID));
    per(3, E_TAB[0]);
    chk("run_cur_sel", int'(cur_sel), 0);
    chk("run_busy", int'(busy), 0);

    // Host switch to src2: waits for a frame event, then exactly 8 muted samples
    req(3'd2);
    idle(2);
    chk("pend_busy", int'(busy), 1);
    per(2, E_TAB[0]);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);  // frame_mark without symbol strobe
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);  // symbol strobe without frame_mark
    per(1, E_TAB[0]);
    fe_cyc();
    per(7, MID);
    chk("mute_busy", int'(busy), 1);
    per(1, MID);
    chk("sw1_cur_sel", int'(cur_sel), 2);
    chk("sw1_busy", int'(busy), 0);
    chk("sw1_count", int'(switch_count), 1);
    per(2, E_TAB[2]);

    // Out-of-range request, then a request for the current source
    req(3'd5);
    idle(2);
    chk("bad_req_err", int'(req_err), 1);
    chk("bad_req_busy", int'(busy), 0);
    req(3'd2);
    idle(2);
    chk("same_req_busy", int'(busy), 0);
    fe_cyc();
    per(2, E_TAB[2]);
    chk("same_req_count", int'(switch_count), 1);
    chk("req_err_sticky", int'(req_err), 1);

    // Retarget while pending and again while muted
    req(3'd0);
    idle(2);
    chk("retarget_busy", int'(busy), 1);
    req(3'd3);
    fe_cyc();
    per(3, MID);
    req(3'd1);
    per(5, MID);
    chk("retarget_cur_sel", int'(cur_sel), 1);
    chk("retarget_count", int'(switch_count), 2);
    per(1, E_TAB[1]);

    // Reset in the middle of a mute window
    req(3'd0);
    idle(2);
    fe_cyc();
    per(3, MID);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mid_rst_dac", int'(dac_out), int'(MID));
    chk("mid_rst_cur_sel", int'(cur_sel), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(switch_count), 0);
    chk("mid_rst_req_err", int'(req_err), 0);
    per(1, E_TAB[0]);

    // Auto-scan, two frame events per advance: 0,1,2,3,0
    auto_scan = 1'b1;
    for (int r = 0; r < 4; r++) begin
      fe_cyc();
      per(1, E_TAB[r]);
      chk("scan_first_fe_busy", int'(busy), 0);
      fe_cyc();
      per(8, MID);
      chk("scan_cur_sel", int'(cur_sel), (r + 1) % 4);
      chk("scan_count", int'(switch_count), r + 1);
    end
    per(1, E_TAB[0]);

    // Deasserting auto_scan holds the partial count
    fe_cyc();
    auto_scan = 1'b0;
    fe_cyc();
    fe_cyc();
    per(1, E_TAB[0]);
    chk("scan_hold_busy", int'(busy), 0);
    auto_scan = 1'b1;
    fe_cyc();
    chk("scan_resume_busy", int'(busy), 1);
    per(8, MID);
    chk("scan_resume_cur_sel", int'(cur_sel), 1);
    chk("scan_resume_count", int'(switch_count), 5);

    // External request on the same frame event that would fire the scan
    fe_cyc();
    per(1, E_TAB[1]);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, '0);
    idle(1);
    chk("coincide_busy", int'(busy), 1);
    per(1, E_TAB[1]);
    fe_cyc();
    per(8, MID);
    chk("coincide_cur_sel", int'(cur_sel), 3);
    chk("coincide_count", int'(switch_count), 6);
    per(1, E_TAB[3]);
    auto_scan = 1'b0;

    idle(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
